// File: rtl/gate_sweep_checker.sv
// Sweeps every input combination of a combinational gate in ascending order,
// samples its output after a settle delay and checks it against a truth table.
module gate_sweep_checker #(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 1,
  parameter logic [2**N_IN-1:0]  EXPECT = 4'b0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            first_fail_valid
);

  // The done pulse is a registered flag, so no separate DONE_PULSE state.
  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t          state_q;
  logic [N_IN-1:0] stim_q;
  logic [3:0]      cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic [N_IN:0]   err_d;
  logic [N_IN-1:0] ffi_q;
  logic            ffv_q;
  logic            mismatch;
  logic            last_vec;

  // Case-inequality so an X or Z from the gate is flagged in simulation.
  always_comb begin
    mismatch = (dut_out !== EXPECT[stim_q]);
    last_vec = (stim_q == {N_IN{1'b1}});
    err_d    = err_q + (N_IN+1)'(mismatch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            stim_q  <= '0;
            cnt_q   <= SETTLE_CNT;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            err_q <= err_d;
            if (mismatch && !ffv_q) begin
              ffi_q <= stim_q;
              ffv_q <= 1'b1;
            end
            if (!last_vec) begin
              stim_q <= stim_q + 1'b1;
              cnt_q  <= SETTLE_CNT;
            end else begin
              // err_d already includes this final vector's result.
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              stim_q  <= '0;
              pass_q  <= (err_d == '0);
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: gate models drive dut_out, predicted sweep
// results are queued at start and compared when done pulses.
module tb_gate_sweep_checker;

  localparam logic [3:0] TT_NOR = 4'b0001;
  localparam logic [3:0] TT_AND = 4'b1000;

  logic clk = 1'b0;
  logic rst, start, start0;
  logic dut_out, dut0_out;
  logic [1:0] stim, stim0, ffi, ffi0;
  logic busy, done, pass, ffv, busy0, done0, pass0, ffv0;
  logic [2:0] err, err0;
  int mode = 0;
  int edge_cnt = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         lat;
    logic [6:0] res;  // {pass, err_count, first_fail_idx, first_fail_valid}
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // 0 NOR, 1 stuck-0, 2 OR, 3 AND, 4 NOR with X on vector 2
  function automatic logic gate_model(int m, logic [1:0] v);
    case (m)
      0: return ~(v[0] | v[1]);
      1: return 1'b0;
      2: return v[0] | v[1];
      3: return v[0] & v[1];
      4: return (v == 2'd2) ? 1'bx : ~(v[0] | v[1]);
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t predict(int m, int settle, logic [3:0] tt);
    exp_t e;
    logic o;
    logic [2:0] ec;
    logic [1:0] fi;
    logic fv;
    ec = '0; fi = '0; fv = 1'b0;
    for (int v = 0; v < 4; v++) begin
      o = gate_model(m, 2'(v));
      if (o !== tt[v]) begin
        ec = ec + 3'd1;
        if (!fv) begin fi = 2'(v); fv = 1'b1; end
      end
    end
    e.lat = 4 * (settle + 1);
    e.res = {(ec == 3'd0), ec, fi, fv};
    return e;
  endfunction

  assign dut_out  = gate_model(mode, stim);
  assign dut0_out = gate_model(3, stim0);

  gate_sweep_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out), .stim(stim),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_fail_idx(ffi), .first_fail_valid(ffv)
  );

  gate_sweep_checker #(.N_IN(2), .SETTLE(0), .EXPECT(TT_AND)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_out(dut0_out), .stim(stim0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_idx(ffi0), .first_fail_valid(ffv0)
  );

  // Returns at the negedge right after the edge that accepted start.
  task automatic pulse_start(input bit sel, output int st);
    @(negedge clk);
    if (sel) start0 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start = 1'b0;
    st = edge_cnt;
  endtask

  task automatic wait_done(input bit sel, output int de, output bit ok);
    ok = 1'b0;
    de = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if ((sel ? done0 : done) === 1'b1) begin
        ok = 1'b1;
        de = edge_cnt;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    logic [13:0] obs;
    rst = 1'b1; start = 1'b0; start0 = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    obs = {stim, busy, done, pass, err, ffi, ffv, busy0, done0};
    n_cmp++;
    if (obs !== 14'd0) begin n_err++; $display("FAIL reset_outputs got %b want 0", obs); end
    obs = {stim0, pass0, err0, ffi0, ffv0, 5'd0};
    n_cmp++;
    if (obs !== 14'd0) begin n_err++; $display("FAIL reset_outputs0 got %b want 0", obs); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nor_sweep;
    int st, de;
    bit ok;
    exp_t e;
    mode = 0;
    sb.push_back(predict(0, 1, TT_NOR));
    pulse_start(1'b0, st);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (stim !== 2'(i / 2) || busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL nor_seq[%0d] stim/busy/done got %0d/%b/%b want %0d/1/0", i, stim, busy, done, i / 2);
      end
      @(negedge clk);
    end
    wait_done(1'b0, de, ok);
    e = sb.pop_front();
    $display("sweep nor: lat=%0d pass=%b err=%0d ffi=%0d ffv=%b", de - st, pass, err, ffi, ffv);
    n_cmp++;
    if (!ok || de - st !== e.lat) begin n_err++; $display("FAIL nor_latency got %0d want %0d", de - st, e.lat); end
    n_cmp++;
    if ({pass, err, ffi, ffv} !== e.res) begin n_err++; $display("FAIL nor_result got %b want %b", {pass, err, ffi, ffv}, e.res); end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, stim, pass} !== 5'b00001) begin
      n_err++; $display("FAIL nor_after got %b want 00001", {done, busy, stim, pass});
    end
  endtask

  task automatic test_fault_models;
    int models[3] = '{1, 2, 4};
    int st, de;
    bit ok;
    exp_t e;
    foreach (models[k]) begin
      mode = models[k];
      sb.push_back(predict(mode, 1, TT_NOR));
      pulse_start(1'b0, st);
      wait_done(1'b0, de, ok);
      e = sb.pop_front();
      $display("sweep model%0d: lat=%0d pass=%b err=%0d ffi=%0d ffv=%b", mode, de - st, pass, err, ffi, ffv);
      n_cmp++;
      if (!ok || de - st !== e.lat) begin n_err++; $display("FAIL model%0d_latency got %0d want %0d", mode, de - st, e.lat); end
      n_cmp++;
      if ({pass, err, ffi, ffv} !== e.res) begin n_err++; $display("FAIL model%0d_result got %b want %b", mode, {pass, err, ffi, ffv}, e.res); end
      @(negedge clk);
    end
    mode = 0;
  endtask

  task automatic test_start_while_busy;
    int st, de, st2, de1, de2;
    bit ok;
    exp_t e;
    mode = 0;
    sb.push_back(predict(0, 1, TT_NOR));
    pulse_start(1'b0, st);
    repeat (2) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;   // sampled at edge st+3
    @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;   // sampled at edge st+5
    n_cmp++;
    if ({busy, stim} !== 3'b110) begin n_err++; $display("FAIL busy_ignore got %b want 110", {busy, stim}); end
    wait_done(1'b0, de, ok);
    e = sb.pop_front();
    $display("sweep restart_ignored: lat=%0d pass=%b err=%0d", de - st, pass, err);
    n_cmp++;
    if (!ok || de - st !== e.lat) begin n_err++; $display("FAIL ignore_latency got %0d want %0d", de - st, e.lat); end
    n_cmp++;
    if ({pass, err, ffi, ffv} !== e.res) begin n_err++; $display("FAIL ignore_result got %b want %b", {pass, err, ffi, ffv}, e.res); end

    // Back-to-back: start held from the done cycle onward.
    start = 1'b1;
    sb.push_back(predict(0, 1, TT_NOR));
    sb.push_back(predict(0, 1, TT_NOR));
    @(negedge clk);
    st2 = edge_cnt;
    n_cmp++;
    if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL b2b_accept got %b want 10", {busy, done}); end
    wait_done(1'b0, de1, ok);
    e = sb.pop_front();
    $display("sweep b2b_1: lat=%0d pass=%b err=%0d", de1 - st2, pass, err);
    n_cmp++;
    if (!ok || de1 - st2 !== e.lat) begin n_err++; $display("FAIL b2b1_latency got %0d want %0d", de1 - st2, e.lat); end
    @(negedge clk);
    wait_done(1'b0, de2, ok);
    e = sb.pop_front();
    start = 1'b0;
    $display("sweep b2b_2: gap=%0d pass=%b err=%0d", de2 - de1, pass, err);
    n_cmp++;
    if (!ok || de2 - de1 !== e.lat + 1) begin n_err++; $display("FAIL b2b2_gap got %0d want %0d", de2 - de1, e.lat + 1); end
    n_cmp++;
    if ({pass, err, ffi, ffv} !== e.res) begin n_err++; $display("FAIL b2b2_result got %b want %b", {pass, err, ffi, ffv}, e.res); end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL b2b_idle got %b want 00", {busy, done}); end
  endtask

  task automatic test_mid_sweep_reset;
    int st, de, highs;
    bit ok;
    exp_t e;
    mode = 2;
    pulse_start(1'b0, st);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err !== 3'd1) begin n_err++; $display("FAIL pre_reset_err got %0d want 1", err); end
    rst = 1'b1;
    @(negedge clk);                                 // after edge st+4
    rst = 1'b0;
    n_cmp++;
    if ({busy, stim, err, pass, done, ffv} !== 9'd0) begin
      n_err++; $display("FAIL rst_mid got %b want 0", {busy, stim, err, pass, done, ffv});
    end
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) highs++;
    end
    n_cmp++;
    if (highs !== 0) begin n_err++; $display("FAIL rst_no_done got %0d active cycles want 0", highs); end
    mode = 0;
    sb.push_back(predict(0, 1, TT_NOR));
    pulse_start(1'b0, st);
    wait_done(1'b0, de, ok);
    e = sb.pop_front();
    $display("sweep after_reset: lat=%0d pass=%b err=%0d", de - st, pass, err);
    n_cmp++;
    if (!ok || de - st !== e.lat) begin n_err++; $display("FAIL post_rst_latency got %0d want %0d", de - st, e.lat); end
    n_cmp++;
    if ({pass, err, ffi, ffv} !== e.res) begin n_err++; $display("FAIL post_rst_result got %b want %b", {pass, err, ffi, ffv}, e.res); end
  endtask

  task automatic test_settle0_and;
    int st, de;
    bit ok;
    exp_t e;
    sb.push_back(predict(3, 0, TT_AND));
    pulse_start(1'b1, st);
    wait_done(1'b1, de, ok);
    e = sb.pop_front();
    $display("sweep settle0_and: lat=%0d pass=%b err=%0d", de - st, pass0, err0);
    n_cmp++;
    if (!ok || de - st !== e.lat) begin n_err++; $display("FAIL and_latency got %0d want %0d", de - st, e.lat); end
    n_cmp++;
    if ({pass0, err0, ffi0, ffv0} !== e.res) begin n_err++; $display("FAIL and_result got %b want %b", {pass0, err0, ffi0, ffv0}, e.res); end
    @(negedge clk);
    n_cmp++;
    if ({done0, busy0, pass0} !== 3'b001) begin n_err++; $display("FAIL and_after got %b want 001", {done0, busy0, pass0}); end
  endtask

  initial begin
    test_reset();
    test_nor_sweep();
    test_fault_models();
    test_start_while_busy();
    test_mid_sweep_reset();
    test_settle0_and();
    n_cmp++;
    if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
